// File: rtl/unary_pkg.sv
// Shared definitions for the unary stream generator and the unary adder bench:
// FSM state encoding, default frame timing and the internal counter width.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WRITE  = 2'd2
  } state_e;

  // Default number of stream (read-mode) and write-mode cycles per frame.
  localparam int FRAME_LEN_DEF = 15;
  localparam int WRITE_LEN_DEF = 20;

  // Frame and write lengths are limited to 255, so 8 bits cover every count.
  localparam int CNT_W = 8;

endpackage

// File: rtl/unary_thermo_cmp.sv
// Thermometer comparator: a stream bit is 1 while the cycle counter is below
// the (already saturated) operand, giving 'operand' leading ones per frame.
module unary_thermo_cmp
  import unary_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] a_eff_i,
  input  logic [CNT_W-1:0] b_eff_i,
  output logic             a_o,
  output logic             b_o
);

  // Pure compare; the caller registers the result.
  always_comb begin
    a_o = (cnt_i < a_eff_i);
    b_o = (cnt_i < b_eff_i);
  end

endmodule

// File: rtl/unary_stream_gen.sv
// Unary stream generator: converts a binary operand pair into two thermometer
// bit streams for a downstream unary adder, followed by a write phase in which
// the adder emits its count. All downstream outputs are registered.
//
// Optional feature (macro UNARY_GEN_SKID_EN): a one-entry pending buffer that
// accepts the next operand pair while a frame is running and launches it
// immediately after the current frame's done cycle.
module unary_stream_gen
  import unary_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int WRITE_LEN = WRITE_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             read_or_write,
  output logic             done
);

  // Width used to compare an operand against FRAME_LEN without truncating either.
  localparam int OW = (WIDTH > CNT_W) ? WIDTH : CNT_W;

  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST  = CNT_W'(WRITE_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_SAT   = CNT_W'(FRAME_LEN);

  // Clamp an operand to FRAME_LEN so an oversized value gives an all-ones
  // stream instead of wrapping.
  function automatic logic [CNT_W-1:0] saturate(input logic [WIDTH-1:0] op);
    logic [OW-1:0] op_w;
    op_w = OW'(op);
    if (op_w > OW'(FRAME_LEN)) return FRAME_SAT;
    return op_w[CNT_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] a_eff_q, a_eff_d;
  logic [CNT_W-1:0] b_eff_q, b_eff_d;
  logic             rdy_en_q;

  logic             a_bit_q, a_bit_d;
  logic             b_bit_q, b_bit_d;
  logic             en_q, en_d;
  logic             rw_q, rw_d;
  logic             done_q, done_d;

  logic             therm_a, therm_b;
  logic             fire;
  logic [CNT_W-1:0] a_in_sat, b_in_sat;

`ifdef UNARY_GEN_SKID_EN
  logic             buf_vld_q, buf_vld_d;
  logic [CNT_W-1:0] buf_a_q, buf_a_d;
  logic [CNT_W-1:0] buf_b_q, buf_b_d;
  logic             last_write;

  assign last_write = (state_q == WRITE) && (cnt_q == WRITE_LAST);
  // Ready whenever the pending slot is free, in any state.
  assign in_ready   = rdy_en_q & ~buf_vld_q;
`else
  // Without the pending slot, new pairs are only taken between frames.
  assign in_ready   = rdy_en_q & (state_q == IDLE);
`endif

  assign fire     = in_valid & in_ready;
  assign a_in_sat = saturate(op_a);
  assign b_in_sat = saturate(op_b);

  // Frame sequencing: next state, cycle counter and captured operands.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    a_eff_d = a_eff_q;
    b_eff_d = b_eff_q;
`ifdef UNARY_GEN_SKID_EN
    buf_vld_d = buf_vld_q;
    buf_a_d   = buf_a_q;
    buf_b_d   = buf_b_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fire) begin
          state_d = STREAM;
          a_eff_d = a_in_sat;
          b_eff_d = b_in_sat;
        end
      end
      STREAM: begin
        if (cnt_q == STREAM_LAST) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (cnt_q == WRITE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef UNARY_GEN_SKID_EN
    // A pair arriving mid-frame is parked in the pending slot.
    if ((state_q != IDLE) && fire) begin
      buf_vld_d = 1'b1;
      buf_a_d   = a_in_sat;
      buf_b_d   = b_in_sat;
    end
    // On the done cycle, chain straight into the next frame: the parked pair
    // first, else a pair arriving on this very edge, bypassing the slot.
    if (last_write) begin
      if (buf_vld_q) begin
        state_d   = STREAM;
        a_eff_d   = buf_a_q;
        b_eff_d   = buf_b_q;
        buf_vld_d = 1'b0;
      end else if (fire) begin
        state_d   = STREAM;
        a_eff_d   = a_in_sat;
        b_eff_d   = b_in_sat;
        buf_vld_d = 1'b0;
      end
    end
`endif
  end

  // Stream bits for the cycle being entered, from the next counter/operands.
  unary_thermo_cmp u_thermo (
    .cnt_i  (cnt_d),
    .a_eff_i(a_eff_d),
    .b_eff_i(b_eff_d),
    .a_o    (therm_a),
    .b_o    (therm_b)
  );

  // Decode the next state into output values so the outputs can be flops.
  always_comb begin
    en_d    = (state_d != IDLE);
    rw_d    = (state_d == WRITE);
    done_d  = (state_d == WRITE) && (cnt_d == WRITE_LAST);
    a_bit_d = (state_d == STREAM) && therm_a;
    b_bit_d = (state_d == STREAM) && therm_b;
  end

  // FSM, counter and operand registers; rdy_en_q holds off acceptance until
  // the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_eff_q  <= '0;
      b_eff_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_eff_q  <= a_eff_d;
      b_eff_q  <= b_eff_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Registered downstream outputs, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_bit_q <= 1'b0;
      b_bit_q <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_bit_q <= a_bit_d;
      b_bit_q <= b_bit_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
    end
  end

`ifdef UNARY_GEN_SKID_EN
  // Pending slot; a reset discards any parked pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q <= 1'b0;
      buf_a_q   <= '0;
      buf_b_q   <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_a_q   <= buf_a_d;
      buf_b_q   <= buf_b_d;
    end
  end
`endif

  assign A             = a_bit_q;
  assign B             = b_bit_q;
  assign en            = en_q;
  assign read_or_write = rw_q;
  assign done          = done_q;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Bench for unary_stream_gen: a default instance (FRAME_LEN 15, WRITE_LEN 20)
// and a short instance (FRAME_LEN 10, WRITE_LEN 3) checked cycle by cycle
// against an arithmetic model of the frame format.
module tb_unary_stream_gen;

`ifdef UNARY_GEN_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam int FL0 = 15, WL0 = 20;
  localparam int FL1 = 10, WL1 = 3;

  logic       clk, rst;
  logic       vld0, vld1;
  logic [3:0] op_a, op_b;
  logic       rdy0, a0, b0, en0, rw0, done0;
  logic       rdy1, a1, b1, en1, rw1, done1;

  int vectors = 0;
  int miscompares = 0;

  unary_stream_gen #(.WIDTH(4), .FRAME_LEN(FL0), .WRITE_LEN(WL0)) dut (
    .clk(clk), .rst(rst), .in_valid(vld0), .in_ready(rdy0),
    .op_a(op_a), .op_b(op_b), .A(a0), .B(b0), .en(en0),
    .read_or_write(rw0), .done(done0)
  );

  unary_stream_gen #(.WIDTH(4), .FRAME_LEN(FL1), .WRITE_LEN(WL1)) dut10 (
    .clk(clk), .rst(rst), .in_valid(vld1), .in_ready(rdy1),
    .op_a(op_a), .op_b(op_b), .A(a1), .B(b1), .en(en1),
    .read_or_write(rw1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] get_obs(input int sel);
    return (sel != 0) ? {a1, b1, en1, rw1, done1} : {a0, b0, en0, rw0, done0};
  endfunction

  function automatic logic get_rdy(input int sel);
    return (sel != 0) ? rdy1 : rdy0;
  endfunction

  // Reference frame: cycle k (1-based after the transfer edge) carries a one on
  // a stream while k <= min(operand, fl); then wl write cycles, done on the last.
  // k == 0 or beyond the frame means idle (all zero).
  function automatic logic [4:0] exp_vec(input int a, input int b, input int k,
                                         input int fl, input int wl);
    int ea, eb;
    ea = (a > fl) ? fl : a;
    eb = (b > fl) ? fl : b;
    if (k <= 0 || k > fl + wl) return 5'b0;
    if (k <= fl) return {(k <= ea), (k <= eb), 1'b1, 1'b0, 1'b0};
    return {1'b0, 1'b0, 1'b1, 1'b1, (k == fl + wl)};
  endfunction

  task automatic cmp_vec(input string name, input int t, input logic [4:0] obs,
                         input logic [4:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d {A,B,en,rw,done} got=%b want=%b", name, t, obs, exp);
    end
  endtask

  task automatic cmp_bit(input string name, input int t, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%b want=%b", name, t, obs, exp);
    end
  endtask

  task automatic set_valid(input int sel, input logic v);
    if (sel != 0) vld1 = v;
    else vld0 = v;
  endtask

  // One complete frame on the selected instance, starting from idle at a negedge.
  task automatic run_frame(input int sel, input int a, input int b, input string name);
    int fl, wl, ones_a, ones_b, ea, eb;
    fl = (sel != 0) ? FL1 : FL0;
    wl = (sel != 0) ? WL1 : WL0;
    ones_a = 0;
    ones_b = 0;
    cmp_bit({name, "_ready_idle"}, 0, get_rdy(sel), 1'b1);
    op_a = 4'(a);
    op_b = 4'(b);
    set_valid(sel, 1'b1);
    @(negedge clk);
    set_valid(sel, 1'b0);
    for (int t = 1; t <= fl + wl; t++) begin
      cmp_vec(name, t, get_obs(sel), exp_vec(a, b, t, fl, wl));
      if (t == 1 || t == fl + wl) cmp_bit({name, "_ready_busy"}, t, get_rdy(sel), SKID);
      if (t <= fl) begin
        ones_a += int'(get_obs(sel) >> 4);
        ones_b += int'(get_obs(sel) >> 3) & 1;
      end
      @(negedge clk);
    end
    ea = (a > fl) ? fl : a;
    eb = (b > fl) ? fl : b;
    vectors++;
    if (ones_a != ea || ones_b != eb) begin
      miscompares++;
      $display("FAIL %s_ones got A=%0d B=%0d want A=%0d B=%0d", name, ones_a, ones_b, ea, eb);
    end
    cmp_vec({name, "_after"}, fl + wl + 1, get_obs(sel), 5'b0);
    cmp_bit({name, "_ready_after"}, fl + wl + 1, get_rdy(sel), 1'b1);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    cmp_vec("reset_dut", 0, get_obs(0), 5'b0);
    cmp_vec("reset_dut10", 0, get_obs(1), 5'b0);
    rst = 1'b0;
    @(negedge clk);
    cmp_bit("reset_ready_dut", 0, get_rdy(0), 1'b1);
    cmp_bit("reset_ready_dut10", 0, get_rdy(1), 1'b1);
    cmp_vec("reset_idle_dut", 0, get_obs(0), 5'b0);
  endtask

  task automatic test_directed;
    run_frame(0, 12, 13, "dir_12_13");
    run_frame(0, 0, 15, "dir_0_15");
    run_frame(0, 15, 0, "dir_15_0");
  endtask

  task automatic test_saturation;
    run_frame(1, 15, 10, "sat_15_10");
    run_frame(1, 9, 11, "sat_9_11");
    run_frame(1, 0, 1, "sat_0_1");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(sel, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "random");
    end
  endtask

  task automatic test_mid_reset;
    int a, b;
    a = int'($urandom_range(6, 15));
    b = int'($urandom_range(6, 15));
    op_a = 4'(a);
    op_b = 4'(b);
    vld0 = 1'b1;
    @(negedge clk);
    vld0 = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      cmp_vec("midrst_pre", t, get_obs(0), exp_vec(a, b, t, FL0, WL0));
      if (t < 5) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 cmp_vec("midrst_async", 5, get_obs(0), 5'b0);
    @(negedge clk);
    cmp_vec("midrst_held", 6, get_obs(0), 5'b0);
    rst = 1'b0;
    @(negedge clk);
    cmp_bit("midrst_ready", 7, get_rdy(0), 1'b1);
    cmp_vec("midrst_no_resume", 7, get_obs(0), 5'b0);
    run_frame(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "midrst_clean");
  endtask

  // Second pair offered from stream cycle 3 of the first frame and held until taken.
  task automatic test_back_to_back;
    int a1v, b1v, a2v, b2v, len, start2, drop;
    logic [4:0] exp;
    logic exp_rdy;
    a1v = int'($urandom_range(0, 15));
    b1v = int'($urandom_range(0, 15));
    a2v = int'($urandom_range(0, 15));
    b2v = int'($urandom_range(0, 15));
    len    = FL0 + WL0;
    start2 = SKID ? len + 1 : len + 2;
    drop   = SKID ? 4 : start2;
    op_a = 4'(a1v);
    op_b = 4'(b1v);
    vld0 = 1'b1;
    @(negedge clk);
    vld0 = 1'b0;
    for (int t = 1; t <= start2 + len; t++) begin
      if (t <= len) exp = exp_vec(a1v, b1v, t, FL0, WL0);
      else exp = exp_vec(a2v, b2v, t - start2 + 1, FL0, WL0);
      if (SKID) exp_rdy = (t <= 3) || (t > len);
      else exp_rdy = (t == len + 1) || (t == start2 + len);
      cmp_vec("b2b", t, get_obs(0), exp);
      cmp_bit("b2b_ready", t, get_rdy(0), exp_rdy);
      if (t == 3) begin
        op_a = 4'(a2v);
        op_b = 4'(b2v);
        vld0 = 1'b1;
      end
      if (t == drop) vld0 = 1'b0;
      if (t < start2 + len) @(negedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      cmp_vec("b2b_accept_once", 0, get_obs(0), 5'b0);
    end
  endtask

  initial begin
    rst  = 1'b1;
    vld0 = 1'b0;
    vld1 = 1'b0;
    op_a = '0;
    op_b = '0;
    test_reset();
    test_directed();
    test_saturation();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
